// File: rtl/jcnt_sample_fifo_pkg.sv
// Shared constants and Johnson-counter decode helpers for the sample FIFO.
package jcnt_pkg;

  localparam int JW_DEF    = 4;
  localparam int WIDTH_DEF = 4;
  // Widest counter the helpers accept; narrower counters are zero-extended.
  localparam int JW_MAX    = 32;

  // Legal Johnson pattern: at most one adjacent-bit transition in the low w bits.
  function automatic logic is_johnson(input logic [JW_MAX-1:0] jcnt, input int w);
    int trans;
    trans = 0;
    for (int i = 0; i < JW_MAX - 1; i++) begin
      if ((i < w - 1) && (jcnt[i] != jcnt[i+1])) trans++;
    end
    return (trans <= 1);
  endfunction

  // All-equal decode (all-zeros or all-ones) over the low w bits.
  function automatic logic is_phase_edge(input logic [JW_MAX-1:0] jcnt, input int w);
    logic all0;
    logic all1;
    all0 = 1'b1;
    all1 = 1'b1;
    for (int i = 0; i < JW_MAX; i++) begin
      if (i < w) begin
        if (jcnt[i]) all0 = 1'b0;
        else         all1 = 1'b0;
      end
    end
    return (all0 || all1);
  endfunction

endpackage

// File: rtl/jcnt_sample_fifo_if.sv
// Consumer-side valid/ready handshake carrying the FIFO head word.
interface jcnt_sample_fifo_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/jcnt_sample_fifo_fifo.sv
// Synchronous FIFO with separate occupancy counter; head word read from registered state.
module sync_fifo
  import jcnt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A pop frees the head slot this cycle, so a push is still accepted when full.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next-state for pointers and occupancy.
  always_comb begin
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  // Storage and pointer registers; reset discards buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/jcnt_sample_fifo.sv
// Samples data on each Johnson phase entry, buffers it, and flags overflow / illegal patterns.
module jcnt_sample_fifo
  import jcnt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int JW    = JW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [JW-1:0]            jcnt_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     clr_flags,
  jcnt_sample_fifo_if.master       out_if,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     illegal_state
);

  logic [JW-1:0]     prev_jcnt_q;
  logic              overflow_q, overflow_d;
  logic              illegal_q, illegal_d;
  logic [JW_MAX-1:0] jcnt_ext;
  logic              strobe, legal, pop, full, empty, drop;

  assign jcnt_ext = JW_MAX'(jcnt_in);
  assign legal    = is_johnson(jcnt_ext, JW);
  assign strobe   = is_phase_edge(jcnt_ext, JW) && (jcnt_in != prev_jcnt_q);
  assign pop      = !empty && out_if.out_ready;
  assign drop     = strobe && full && !pop;

  assign out_if.out_valid = !empty;
  assign overflow         = overflow_q;
  assign illegal_state    = illegal_q;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (strobe),
    .pop_i   (pop),
    .wdata_i (data_in),
    .rdata_o (out_if.out_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Sticky flags: a set event outranks a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    if (clr_flags) begin
      overflow_d = 1'b0;
      illegal_d  = 1'b0;
    end
    if (drop)   overflow_d = 1'b1;
    if (!legal) illegal_d  = 1'b1;
  end

  // Previous counter state for edge detection, plus flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_jcnt_q <= '0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      prev_jcnt_q <= jcnt_in;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_jcnt_sample_fifo.sv
// Directed bench for jcnt_sample_fifo: vector table plus hand-written multi-cycle sequences.
module tb_jcnt_sample_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] jcnt;
  logic [3:0] din;
  logic       clr;
  logic [2:0] count;
  logic       ovf;
  logic       ill;

  int vectors     = 0;
  int miscompares = 0;

  jcnt_sample_fifo_if #(.WIDTH(4)) bus ();

  jcnt_sample_fifo #(.WIDTH(4), .JW(4), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .jcnt_in       (jcnt),
    .data_in       (din),
    .clr_flags     (clr),
    .out_if        (bus),
    .count         (count),
    .overflow      (ovf),
    .illegal_state (ill)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       r;
    logic [3:0] j;
    logic [3:0] d;
    logic       c;
    logic       rdy;
    logic       ev;
    logic [3:0] ed;
    logic [2:0] ec;
    logic       eo;
    logic       ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic r, logic [3:0] j, logic [3:0] d, logic c, logic rdy,
                              logic ev, logic [3:0] ed, logic [2:0] ec, logic eo, logic ei);
    vec_t v;
    v.name = nm; v.r = r; v.j = j; v.d = d; v.c = c; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.ei = ei;
    return v;
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic apply(input logic r, input logic [3:0] j, input logic [3:0] d,
                       input logic c, input logic rdy);
    rst = r; jcnt = j; din = d; clr = c; bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Head data is only meaningful while valid, or right after reset (memory cleared).
  task automatic check(input string nm, input logic chk_d, input logic ev, input logic [3:0] ed,
                       input logic [2:0] ec, input logic eo, input logic ei);
    vectors++;
    if (bus.out_valid !== ev || (chk_d && bus.out_data !== ed) || count !== ec ||
        ovf !== eo || ill !== ei) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b data=%h count=%0d ovf=%0b ill=%0b, want valid=%0b data=%h count=%0d ovf=%0b ill=%0b",
               nm, bus.out_valid, bus.out_data, count, ovf, ill, ev, ed, ec, eo, ei);
    end
  endtask

  initial begin
    // Johnson walk with consumer ready: each sample visible for one cycle.
    tbl.push_back(mk("reset",     1, 4'b0000, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("j1000",     0, 4'b1000, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("j1100",     0, 4'b1100, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("j1110",     0, 4'b1110, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("strobe1111",0, 4'b1111, 4'h1, 0, 1, 1, 4'h1, 1, 0, 0));
    tbl.push_back(mk("pop1",      0, 4'b0111, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("j0011",     0, 4'b0011, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("j0001",     0, 4'b0001, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("strobe0000",0, 4'b0000, 4'h9, 0, 1, 1, 4'h9, 1, 0, 0));
    tbl.push_back(mk("pop9",      0, 4'b1000, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    // Holding 1111 produces a single push.
    tbl.push_back(mk("h1100",     0, 4'b1100, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("h1110",     0, 4'b1110, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("hold1",     0, 4'b1111, 4'h3, 0, 0, 1, 4'h3, 1, 0, 0));
    tbl.push_back(mk("hold2",     0, 4'b1111, 4'h4, 0, 0, 1, 4'h3, 1, 0, 0));
    tbl.push_back(mk("hold3",     0, 4'b1111, 4'h4, 0, 0, 1, 4'h3, 1, 0, 0));
    tbl.push_back(mk("h0111",     0, 4'b0111, 4'h0, 0, 0, 1, 4'h3, 1, 0, 0));
    tbl.push_back(mk("hpop",      0, 4'b0011, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0));
    // Illegal pattern detection and sticky clear priority.
    tbl.push_back(mk("ill1010",   0, 4'b1010, 4'h0, 0, 1, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk("illclr",    0, 4'b0011, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk("illsetwin", 0, 4'b0101, 4'h0, 1, 1, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk("illsticky", 0, 4'b0001, 4'h0, 0, 1, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk("illclr2",   0, 4'b0001, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0));

    apply(1, 4'b0000, 4'h0, 0, 0);
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].j, tbl[i].d, tbl[i].c, tbl[i].rdy);
      check(tbl[i].name, tbl[i].ev || tbl[i].r, tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].eo, tbl[i].ei);
    end

    // Five strobes with the consumer stalled: fifth is dropped.
    for (int k = 1; k <= 5; k++) begin
      apply(0, (k % 2 == 1) ? 4'b0000 : 4'b1111, 4'(k), 0, 0);
      check($sformatf("fill%0d", k), 1, 1, 4'h1, (k >= 4) ? 3'd4 : 3'(k), (k == 5), 0);
    end
    for (int i = 1; i <= 4; i++) begin
      apply(0, 4'b0000, 4'h0, 0, 1);
      check($sformatf("drain%0d", i), (i < 4), (i < 4), 4'(i + 1), 3'(4 - i), 1, 0);
    end

    // Full FIFO: strobe and pop in the same cycle is accepted without overflow.
    apply(0, 4'b0000, 4'h0, 1, 0);
    check("ovfclr", 0, 0, 4'h0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      apply(0, (k % 2 == 0) ? 4'b1111 : 4'b0000, 4'(6 + k), 0, 0);
      check($sformatf("refill%0d", k), 1, 1, 4'h6, 3'(k + 1), 0, 0);
    end
    apply(0, 4'b1111, 4'hA, 0, 1);
    check("pushpop_full", 1, 1, 4'h7, 4, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      apply(0, 4'b1111, 4'h0, 0, 1);
      check($sformatf("drainA%0d", i), (i < 4), (i < 4), 4'(7 + i), 3'(4 - i), 0, 0);
    end

    // Reset with three words buffered and a flag set.
    apply(0, 4'b0110, 4'h0, 0, 0);
    check("pre_ill", 0, 0, 4'h0, 0, 0, 1);
    apply(0, 4'b0000, 4'h1, 0, 0);
    apply(0, 4'b1111, 4'h2, 0, 0);
    apply(0, 4'b0000, 4'h3, 0, 0);
    check("three_words", 1, 1, 4'h1, 3, 0, 1);
    apply(1, 4'b1111, 4'hF, 0, 0);
    check("midreset", 1, 0, 4'h0, 0, 0, 0);
    apply(0, 4'b1111, 4'h5, 0, 0);
    check("post_reset_push", 1, 1, 4'h5, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jcnt_sample_fifo.md
# jcnt_sample_fifo

Downstream capture stage for the Johnson-counter-gated data latch. Each time the 4-phase Johnson counter enters an all-equal state (all-zeros or all-ones), the block samples the latched data word. It buffers the samples in a small FIFO and presents them to a consumer over a valid/ready handshake. It also flags buffer overflow and any illegal (non-Johnson) counter pattern.

## Interface
Parameters:
- WIDTH, 4, data word width
- JW, 4, Johnson counter width (≥2)
- DEPTH, 4, FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock; everything is sampled on its rising edge
- rst  in  1  reset; synchronous, active-high
- jcnt_in  in  JW  Johnson counter state
- data_in  in  WIDTH  latched data word, valid while jcnt_in is all-equal
- clr_flags  in  1  synchronous clear of the sticky flags
- out_data  out  WIDTH  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- illegal_state  out  1  sticky: jcnt_in showed a non-Johnson pattern

## Operation
- A register `prev_jcnt` holds the previous jcnt_in. Its reset value is all-zeros.
- Strobe condition: jcnt_in is all-zeros or all-ones, AND jcnt_in ≠ prev_jcnt.
  - The strobe fires once per entry into a phase. Holding a state produces no further strobes.
  - For JW=4 the sequence is 0000→1000→1100→1110→1111→0111→0011→0001→0000, giving one strobe every 4 cycles.
- Legal pattern: at most one adjacent-bit transition across jcnt_in[JW-1:0], i.e. a contiguous run of ones or a contiguous run of zeros.
  - An illegal pattern sets illegal_state. It does not affect the FIFO.
- Push: a strobe pushes data_in, provided the FIFO is not full or a pop happens in the same cycle.
  - A strobe while full with no pop drops the sample and sets overflow.
- Pop: occurs when out_valid && out_ready. out_ready is ignored when the FIFO is empty.
- Simultaneous push and pop:
  - count is unchanged.
  - Allowed at both full and non-empty occupancy.
  - When empty, a push is the only event, since a pop cannot occur.
- Pointers: read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. count is kept as a separate register.
- Sticky flags:
  - clr_flags clears them.
  - If a set event and clr_flags occur in the same cycle, set wins.
- Reset: clears pointers, count, flags and prev_jcnt. Reset mid-operation discards all buffered data.

## Timing
- All outputs are registered, or decoded combinationally from registered state. There is no combinational path from inputs to outputs.
- Reset values: out_valid=0, count=0, overflow=0, illegal_state=0, out_data=0 (memory is cleared on reset).
- Push latency: a strobe in cycle N makes out_valid=1 in cycle N+1 with out_data = the sampled word (when the FIFO was empty).
- Pop: the handshake in cycle N advances the head. The next word (or out_valid=0) appears in cycle N+1.
- Flags assert in the cycle after the triggering event.
- rst takes priority over every other input in the same cycle.

## Structure
- Package `jcnt_pkg` holds:
  - default JW and WIDTH constants;
  - function `is_johnson(jcnt)` (legality check);
  - function `is_phase_edge(jcnt)` (all-equal decode).
- Natural sub-module: `sync_fifo` (WIDTH, DEPTH; push/pop/full/empty/count).
- Top level: strobe detect, legality check, overflow logic.

## Test plan
- Reset, run the Johnson sequence with out_ready=1, data_in=0x1 at 1111 and 0x9 at the following 0000 → out_data 0x1 then 0x9, each with out_valid for one cycle, one cycle after its strobe.
- out_ready=0, five strobes carrying 0x1..0x5 → count=4, overflow=1 after the fifth; drain gives 0x1,0x2,0x3,0x4.
- FIFO full, strobe with data 0xA in the same cycle as a pop → count stays 4, overflow stays 0; 0xA is the last word drained.
- jcnt_in held at 1111 for 3 cycles, then 0111 → exactly one push.
- jcnt_in=1010 for one cycle → illegal_state=1 next cycle, count unchanged; clr_flags alone clears it; clr_flags together with a new illegal pattern leaves it set.
- FIFO holding 3 words, rst pulsed for one cycle → next cycle count=0, out_valid=0, flags=0; a subsequent strobe pushes normally.
